// File: rtl/dmem_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dmem_responder_if                                           |
// | Purpose  : dmem request/response handshake between the load/store      |
// |            unit (master) and a data-memory responder (slave).          |
// | Signals  : dmem_rqst   - single-cycle request strobe (master -> slave) |
// |            dmem_addr   - byte address                                   |
// |            dmem_rmask  - read byte mask                                 |
// |            dmem_wmask  - write byte mask, nonzero means write           |
// |            dmem_wdata  - write data, lanes aligned to mask              |
// |            dmem_rdata  - read data, valid in the dmem_resp cycle only   |
// |            dmem_resp   - one-cycle response pulse (slave -> master)     |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface dmem_responder_if;
  logic        dmem_rqst;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_rqst, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_rqst, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dmem_responder                                              |
// | Purpose  : Data-memory responder behind the load/store unit. Performs  |
// |            reads and byte-masked writes on a word-addressed array at   |
// |            the acceptance edge and acknowledges after a latency.        |
// | Ports    : clk, rst    - clock, synchronous active-high reset           |
// |            flush       - pipeline flush, cancels outstanding response   |
// |            bus (slave) - dmem request/response handshake                |
// |            busy        - request outstanding (BUSY or RESP)             |
// |            proto_err   - sticky: request seen while busy                |
// | Options  : DMEM_RESPONDER_RAND_LAT_EN - adds LFSR-randomised latency    |
// |            (LATENCY .. LATENCY+7); undefined gives fixed LATENCY.       |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int INIT_ZERO   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  dmem_responder_if.slave  bus,
  output logic             busy,
  output logic             proto_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Wide enough for LATENCY (max 15) plus the random extension (max 7).
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               proto_err_q, proto_err_d;

  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               do_write;
  logic [31:0]        rd_word;
  logic [31:0]        rmask_bits;
  logic [CNT_W-1:0]   lat;

  // Upper address bits alias modulo DEPTH_WORDS; byte offset is ignored.
  assign idx      = bus.dmem_addr[IDX_W+1:2];
  assign accept   = (state_q == S_IDLE) && bus.dmem_rqst && !flush;
  assign do_write = accept && (bus.dmem_wmask != 4'b0000);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.dmem_addr[31:IDX_W+2], bus.dmem_addr[1:0]};

  always_comb begin
    rmask_bits = '0;
    for (int b = 0; b < 4; b++) begin
      rmask_bits[8*b +: 8] = {8{bus.dmem_rmask[b]}};
    end
  end

  // Storage. Zero-initialisation happens once at time zero; rst never
  // touches the array contents.
  if (INIT_ZERO != 0) begin : g_mem_init
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};
    always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
        if (do_write && bus.dmem_wmask[b]) begin
          mem_q[idx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
        end
      end
    end
    assign rd_word = mem_q[idx];
  end else begin : g_mem_noinit
    logic [31:0] mem_q [DEPTH_WORDS];
    always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
        if (do_write && bus.dmem_wmask[b]) begin
          mem_q[idx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
        end
      end
    end
    assign rd_word = mem_q[idx];
  end

`ifdef DMEM_RESPONDER_RAND_LAT_EN
  // Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, free-running.
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lat = CNT_W'(LATENCY) + {{(CNT_W-3){1'b0}}, lfsr_q[2:0]};
`else
  assign lat = CNT_W'(LATENCY);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    proto_err_d = proto_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Writes return zero data; a read with an empty mask returns 0.
          rdata_d = do_write ? 32'h0 : (rd_word & rmask_bits);
          if (lat <= CNT_W'(1)) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = lat - CNT_W'(1);
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (bus.dmem_rqst) begin
            proto_err_d = 1'b1;
          end
          // The count reaching zero coincides with entering RESP.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (!flush && bus.dmem_rqst) begin
          proto_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // flush masks the response in the same cycle it is asserted.
  assign bus.dmem_resp  = (state_q == S_RESP) && !flush;
  assign bus.dmem_rdata = bus.dmem_resp ? rdata_q : 32'h0;
  assign busy           = (state_q != S_IDLE);
  assign proto_err      = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                           |
// | Purpose  : Self-checking bench for dmem_responder: vector table plus    |
// |            hand-written flush / protocol / reset sequences, with a      |
// |            response scoreboard.                                         |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
`ifdef DMEM_RESPONDER_RAND_LAT_EN
  localparam int LAT_MAX = LAT + 7;
`else
  localparam int LAT_MAX = LAT;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  logic proto_err;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .INIT_ZERO  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .busy     (busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          issue;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   lat_log[$];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one request for one cycle; the scoreboard entry records the cycle
  // in which it was driven so the monitor can measure the latency.
  task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                     input logic [31:0] wd, input logic [31:0] ex, input bit fl,
                     input bit push);
    exp_t e;
    bus.dmem_rqst  = 1'b1;
    bus.dmem_addr  = a;
    bus.dmem_rmask = rm;
    bus.dmem_wmask = wm;
    bus.dmem_wdata = wd;
    flush          = fl;
    if (push) begin
      e.issue = cyc;
      e.data  = ex;
      sb.push_back(e);
    end
    tick(1);
    bus.dmem_rqst  = 1'b0;
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
    flush          = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    check({name, "_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tick(2);
    rst = 1'b0;
  endtask

  // Response monitor, sampled on the falling edge.
  exp_t mon_e;
  int   mon_l;
  always @(negedge clk) begin
    if (bus.dmem_resp) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        mon_l = cyc - mon_e.issue;
        lat_log.push_back(mon_l);
`ifdef DMEM_RESPONDER_RAND_LAT_EN
        check("resp_latency_range", 32'((mon_l >= LAT) && (mon_l <= LAT_MAX)), 32'd1);
`else
        check("resp_latency", mon_l, LAT);
`endif
        check("resp_rdata", bus.dmem_rdata, mon_e.data);
      end
    end else begin
      check("idle_rdata", bus.dmem_rdata, 32'h0);
      if (sb.size() > 0 && (cyc - sb[0].issue) > LAT_MAX) begin
        check("missing_resp", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'h0000_0040, 4'h0, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000};
    vt[1]  = '{32'h0000_0040, 4'hF, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF};
    vt[2]  = '{32'h0000_0080, 4'h0, 4'hF, 32'h1122_3344, 32'h0000_0000};
    vt[3]  = '{32'h0000_0080, 4'h0, 4'h2, 32'h0000_AA00, 32'h0000_0000};
    vt[4]  = '{32'h0000_0080, 4'hF, 4'h0, 32'h0000_0000, 32'h1122_AA44};
    vt[5]  = '{32'h0000_0080, 4'h1, 4'h0, 32'h0000_0000, 32'h0000_0044};
    vt[6]  = '{32'h0000_0080, 4'hC, 4'h0, 32'h0000_0000, 32'h1122_0000};
    vt[7]  = '{32'h0000_0000, 4'h0, 4'hF, 32'hCAFE_F00D, 32'h0000_0000};
    vt[8]  = '{32'h0000_1000, 4'hF, 4'h0, 32'h0000_0000, 32'hCAFE_F00D};
    vt[9]  = '{32'h0000_0080, 4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000};
    vt[10] = '{32'h0000_0FFC, 4'h0, 4'h9, 32'hA512_345A, 32'h0000_0000};
    vt[11] = '{32'h0000_3FFE, 4'hF, 4'h0, 32'h0000_0000, 32'hA500_005A};
    vt[12] = '{32'h0000_0044, 4'hF, 4'h0, 32'h0000_0000, 32'h0000_0000};

    rst            = 1'b1;
    flush          = 1'b0;
    bus.dmem_rqst  = 1'b0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
    bus.dmem_wdata = 32'h0;
    tick(3);
    check("rst_resp",      bus.dmem_resp,  32'h0);
    check("rst_rdata",     bus.dmem_rdata, 32'h0);
    check("rst_busy",      busy,           32'h0);
    check("rst_proto_err", proto_err,      32'h0);
    rst = 1'b0;
    tick(1);

    // Table-driven transactions, each waiting for its response.
    for (int i = 0; i < 13; i++) begin
      req(vt[i].addr, vt[i].rmask, vt[i].wmask, vt[i].wdata, vt[i].exp_rdata, 1'b0, 1'b1);
      drain($sformatf("vec%0d", i));
    end

    // Flush while BUSY: no response, idle next cycle, new read accepted.
    req(32'h40, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    check("flush_busy_pre", busy, 32'h1);
    flush = 1'b1;
    sb.delete();
    tick(1);
    flush = 1'b0;
    check("flush_busy_post", busy, 32'h0);
    req(32'h40, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    drain("flush_busy_reread");

`ifndef DMEM_RESPONDER_RAND_LAT_EN
    // Flush in the RESP cycle masks the response combinationally.
    req(32'h80, 4'hF, 4'h0, 32'h0, 32'h1122_AA44, 1'b0, 1'b1);
    tick(LAT - 1);
    flush = 1'b1;
    sb.delete();
    #1;
    check("flush_resp_busy",  busy,          32'h1);
    check("flush_resp_resp",  bus.dmem_resp, 32'h0);
    tick(1);
    flush = 1'b0;
    check("flush_resp_post",  busy,          32'h0);
`endif

    // Flush together with a write request: request dropped, no write.
    req(32'h100, 4'h0, 4'hF, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    check("flush_rqst_busy", busy, 32'h0);
    req(32'h100, 4'hF, 4'h0, 32'h0, 32'h0000_0000, 1'b0, 1'b1);
    drain("flush_rqst_read");

    // Request while busy: sticky error, ignored write, first completes.
    check("perr_before", proto_err, 32'h0);
    req(32'h40, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    req(32'h40, 4'h0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
    check("perr_set", proto_err, 32'h1);
    drain("perr_first");
    req(32'h40, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    drain("perr_ignored_write");
    check("perr_sticky", proto_err, 32'h1);

    // Reset mid-operation: no response, committed write survives.
    req(32'h200, 4'h0, 4'hF, 32'h55AA_55AA, 32'h0, 1'b0, 1'b1);
    rst = 1'b1;
    sb.delete();
    tick(1);
    rst = 1'b0;
    check("midrst_busy", busy,      32'h0);
    check("midrst_perr", proto_err, 32'h0);
    tick(2);
    req(32'h200, 4'hF, 4'h0, 32'h0, 32'h55AA_55AA, 1'b0, 1'b1);
    drain("midrst_read");

`ifdef DMEM_RESPONDER_RAND_LAT_EN
    begin
      int seq_a[$];
      int seq_b[$];
      bit seen[int];
      do_reset();
      lat_log.delete();
      for (int i = 0; i < 20; i++) begin
        req(32'h40, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drain("rand_seq_a");
      end
      seq_a = lat_log;
      do_reset();
      lat_log.delete();
      for (int i = 0; i < 20; i++) begin
        req(32'h40, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drain("rand_seq_b");
      end
      seq_b = lat_log;
      check("rand_seq_len", seq_b.size(), seq_a.size());
      for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++) begin
        check($sformatf("rand_seq_%0d", i), seq_b[i], seq_a[i]);
      end
      lat_log.delete();
      for (int i = 0; i < 200; i++) begin
        req(32'h40, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drain("rand_b2b");
      end
      foreach (lat_log[i]) seen[lat_log[i]] = 1'b1;
      check("rand_distinct_ge4", 32'(seen.num() >= 4), 32'd1);
    end
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
